// File: rtl/hit_judge.sv
// Mole-game player judge: synchronises and debounces eight buttons, classifies
// each press as hit / wrong / empty, detects escaped moles, keeps score and counts.
module hit_judge #(
  parameter int CLK_PER_MS  = 1000,
  parameter int DEBOUNCE_MS = 5
) (
  input  logic       clk_1mhz,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] gsm_stage,
  input  logic [3:0] mole_pos,
  input  logic [7:0] btn,
  output logic [9:0] score,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       mole_hit
);

  localparam logic [9:0] PRESC_MAX = 10'(CLK_PER_MS - 1);
  localparam logic [2:0] DB_LEN    = 3'(DEBOUNCE_MS);
  localparam logic [9:0] SCORE_MAX = 10'd999;
  localparam logic [7:0] CNT_MAX   = 8'd255;

  logic [7:0]      sync1_q, sync1_d;
  logic [7:0]      sync2_q, sync2_d;
  logic [9:0]      presc_q, presc_d;
  logic [7:0]      stable_q, stable_d;
  logic [7:0][2:0] db_cnt_q, db_cnt_d;
  logic [3:0]      pos_q, pos_d;
  logic            en_q, en_d;
  logic [9:0]      score_q, score_d;
  logic [7:0]      hit_cnt_q, hit_cnt_d;
  logic [7:0]      miss_cnt_q, miss_cnt_d;
  logic            hit_pulse_q, hit_pulse_d;
  logic            miss_pulse_q, miss_pulse_d;
  logic            mole_hit_q, mole_hit_d;

  logic            tick;
  logic [7:0]      press;

  // Two-stage synchroniser and free-running millisecond prescaler
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? 10'd0 : presc_q + 10'd1;
  end

  // Debounce: a new level must be seen on DEBOUNCE_MS consecutive ticks
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (tick) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (db_cnt_q[i] + 3'd1 == DB_LEN) begin
            stable_d[i] = sync2_q[i];
            db_cnt_d[i] = 3'd0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 3'd1;
          end
        end else begin
          db_cnt_d[i] = 3'd0;
        end
      end
    end
    press = stable_d & ~stable_q;
  end

  logic       pos_valid, pos_q_valid, new_app, active, en_start;
  logic [7:0] mole_oh;
  logic       hit_avail, hit, press_miss, escape;
  logic [1:0] points, miss_inc;
  logic [10:0] score_sum;
  logic [8:0]  hit_sum, miss_sum;

  always_comb begin
    pos_valid   = (mole_pos >= 4'd1) && (mole_pos <= 4'd8);
    pos_q_valid = (pos_q >= 4'd1) && (pos_q <= 4'd8);
    new_app     = pos_valid && (mole_pos != pos_q);
    en_start    = enable & ~en_q;
    active      = enable & en_q;
    mole_oh     = pos_valid ? (8'd1 << (mole_pos - 4'd1)) : 8'd0;

    // A mole that changed this cycle is a fresh appearance, so it is hittable
    hit_avail   = pos_valid & ~(mole_hit_q & ~new_app);
    hit         = active & hit_avail & (|(press & mole_oh));
    press_miss  = active & ~hit & (pos_valid ? (|(press & ~mole_oh)) : (|press));
    escape      = active & pos_q_valid & (mole_pos != pos_q) & ~mole_hit_q;

    case (gsm_stage)
      2'b10:   points = 2'd2;
      2'b11:   points = 2'd3;
      default: points = 2'd1;
    endcase
    miss_inc  = {1'b0, press_miss} + {1'b0, escape};
    score_sum = {1'b0, score_q} + {9'd0, points};
    hit_sum   = {1'b0, hit_cnt_q} + 9'd1;
    miss_sum  = {1'b0, miss_cnt_q} + {7'd0, miss_inc};
  end

  always_comb begin
    pos_d        = mole_pos;
    en_d         = enable;
    score_d      = score_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    mole_hit_d   = mole_hit_q;

    if (en_start) begin
      score_d    = 10'd0;
      hit_cnt_d  = 8'd0;
      miss_cnt_d = 8'd0;
      mole_hit_d = 1'b0;
    end else if (!enable) begin
      mole_hit_d = 1'b0;
    end else begin
      if (hit) begin
        score_d     = (score_sum > 11'd999) ? SCORE_MAX : score_sum[9:0];
        hit_cnt_d   = hit_sum[8] ? CNT_MAX : hit_sum[7:0];
        hit_pulse_d = 1'b1;
      end
      if (press_miss || escape) begin
        miss_cnt_d   = miss_sum[8] ? CNT_MAX : miss_sum[7:0];
        miss_pulse_d = 1'b1;
      end
      if (hit) begin
        mole_hit_d = 1'b1;
      end else if (!pos_valid || new_app) begin
        mole_hit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      presc_q      <= '0;
      stable_q     <= '0;
      db_cnt_q     <= '0;
      pos_q        <= '0;
      en_q         <= 1'b0;
      score_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      mole_hit_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      presc_q      <= presc_d;
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      pos_q        <= pos_d;
      en_q         <= en_d;
      score_q      <= score_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      mole_hit_q   <= mole_hit_d;
    end
  end

  assign score      = score_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign mole_hit   = mole_hit_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: vector table, hand-built timing corners, and random
// press sequences checked against an event-level model of the game rules.
module tb_hit_judge;
  localparam int CPM = 4;
  localparam int DB  = 5;

  logic       clk_1mhz = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] gsm_stage = 2'd0;
  logic [3:0] mole_pos = 4'd0;
  logic [7:0] btn = 8'd0;
  logic [9:0] score;
  logic [7:0] hit_cnt, miss_cnt;
  logic       hit_pulse, miss_pulse, mole_hit;

  hit_judge #(.CLK_PER_MS(CPM), .DEBOUNCE_MS(DB)) dut (
    .clk_1mhz(clk_1mhz), .rst(rst), .enable(enable), .gsm_stage(gsm_stage),
    .mole_pos(mole_pos), .btn(btn), .score(score), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .mole_hit(mole_hit)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  int cyc = 0;
  int hp_cnt = 0;
  int mp_cnt = 0;
  always @(posedge clk_1mhz) cyc <= cyc + 1;
  always @(negedge clk_1mhz) begin
    if (hit_pulse) hp_cnt = hp_cnt + 1;
    if (miss_pulse) mp_cnt = mp_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_state(input string name, input int s, input int h, input int m, input int mh);
    chk({name, ".score"}, int'(score), s);
    chk({name, ".hit_cnt"}, int'(hit_cnt), h);
    chk({name, ".miss_cnt"}, int'(miss_cnt), m);
    chk({name, ".mole_hit"}, int'(mole_hit), mh);
  endtask

  task automatic wait_ms(input int n);
    repeat (n * CPM) @(negedge clk_1mhz);
  endtask

  // Show a mole, press a button set cleanly, release, let everything settle
  task automatic apply_vec(input logic [1:0] st, input logic [3:0] p, input logic [7:0] m);
    @(negedge clk_1mhz);
    gsm_stage = st;
    mole_pos  = p;
    wait_ms(3);
    btn = m;
    wait_ms(7);
    btn = 8'd0;
    wait_ms(7);
  endtask

  task automatic align_tick_phase();
    while (cyc % CPM != 0) @(negedge clk_1mhz);
  endtask

  task automatic wait_hit(input int t0, output int lat);
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_1mhz);
      if (hit_pulse) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  // Reference model, one event at a time
  int m_pos, m_hit, m_score, m_hits, m_miss;

  function automatic bit is_valid(input int p);
    return (p >= 1) && (p <= 8);
  endfunction

  task automatic model_event(input int st, input int p, input int m);
    int bitm, pts;
    if (p != m_pos) begin
      if (is_valid(m_pos) && m_hit == 0) m_miss = (m_miss >= 255) ? 255 : m_miss + 1;
      m_hit = 0;
      m_pos = p;
    end
    if (m != 0) begin
      if (is_valid(p)) begin
        bitm = 1 << (p - 1);
        pts  = (st == 2) ? 2 : (st == 3) ? 3 : 1;
        if ((m & bitm) != 0 && m_hit == 0) begin
          m_score = (m_score + pts > 999) ? 999 : m_score + pts;
          m_hits  = (m_hits >= 255) ? 255 : m_hits + 1;
          m_hit   = 1;
        end else if ((m & ~bitm & 255) != 0) begin
          m_miss = (m_miss >= 255) ? 255 : m_miss + 1;
        end
      end else begin
        m_miss = (m_miss >= 255) ? 255 : m_miss + 1;
      end
    end
  endtask

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] pos;
    logic [7:0] mask;
    logic [9:0] e_score;
    logic [7:0] e_hit;
    logic [7:0] e_miss;
    logic       e_mh;
  } vec_t;

  vec_t vt [13];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, hp0, mp0, p, m, st, r;

    vt[0]  = '{2'd2, 4'd3,  8'h04, 10'd2,  8'd1, 8'd0, 1'b1};
    vt[1]  = '{2'd2, 4'd3,  8'h04, 10'd2,  8'd1, 8'd0, 1'b1};
    vt[2]  = '{2'd2, 4'd5,  8'h01, 10'd2,  8'd1, 8'd1, 1'b0};
    vt[3]  = '{2'd2, 4'd0,  8'h10, 10'd2,  8'd1, 8'd3, 1'b0};
    vt[4]  = '{2'd2, 4'd4,  8'h48, 10'd4,  8'd2, 8'd3, 1'b1};
    vt[5]  = '{2'd2, 4'd0,  8'h42, 10'd4,  8'd2, 8'd4, 1'b0};
    vt[6]  = '{2'd3, 4'd8,  8'h80, 10'd7,  8'd3, 8'd4, 1'b1};
    vt[7]  = '{2'd1, 4'd2,  8'h01, 10'd7,  8'd3, 8'd5, 1'b0};
    vt[8]  = '{2'd0, 4'd2,  8'h02, 10'd8,  8'd4, 8'd5, 1'b1};
    vt[9]  = '{2'd1, 4'd7,  8'h00, 10'd8,  8'd4, 8'd5, 1'b0};
    vt[10] = '{2'd1, 4'd1,  8'h01, 10'd9,  8'd5, 8'd6, 1'b1};
    vt[11] = '{2'd1, 4'd12, 8'h10, 10'd9,  8'd5, 8'd7, 1'b0};
    vt[12] = '{2'd1, 4'd6,  8'h21, 10'd10, 8'd6, 8'd7, 1'b1};

    repeat (3) @(negedge clk_1mhz);
    chk_state("reset", 0, 0, 0, 0);
    chk("reset.hit_pulse", int'(hit_pulse), 0);
    chk("reset.miss_pulse", int'(miss_pulse), 0);
    rst = 1'b0;
    enable = 1'b1;
    wait_ms(1);

    for (int i = 0; i < 13; i++) begin
      apply_vec(vt[i].st, vt[i].pos, vt[i].mask);
      chk_state($sformatf("vec%0d", i), int'(vt[i].e_score), int'(vt[i].e_hit),
                int'(vt[i].e_miss), int'(vt[i].e_mh));
    end
    chk("table.hit_pulses", hp_cnt, 6);
    chk("table.miss_pulses", mp_cnt, 7);

    // Glitch, then chatter followed by a steady press
    @(negedge clk_1mhz);
    mole_pos = 4'd2;
    wait_ms(3);
    btn = 8'h02;
    wait_ms(3);
    btn = 8'h00;
    wait_ms(8);
    chk_state("glitch", 10, 6, 7, 0);
    for (int k = 0; k < 8; k++) begin
      btn[1] = ~btn[1];
      repeat (CPM / 2) @(negedge clk_1mhz);
    end
    btn = 8'h02;
    wait_ms(8);
    btn = 8'h00;
    wait_ms(8);
    chk_state("chatter", 11, 7, 7, 1);
    chk("chatter.hit_pulses", hp_cnt, 7);

    // Press latency and pulse width
    mole_pos = 4'd0;
    wait_ms(2);
    mole_pos = 4'd1;
    wait_ms(3);
    align_tick_phase();
    btn = 8'h01;
    t0 = cyc;
    wait_hit(t0, lat);
    chk_rng("press_latency", lat, 2 + (DB - 1) * CPM, 2 + (DB + 1) * CPM + 1);
    @(negedge clk_1mhz);
    chk("hit_pulse_width", int'(hit_pulse), 0);
    chk_state("latency", 12, 8, 7, 1);
    btn = 8'h00;
    wait_ms(8);

    // Escape and wrong press landing in the same cycle
    mole_pos = 4'd5;
    wait_ms(3);
    align_tick_phase();
    btn = 8'h01;
    t0 = cyc;
    while (cyc < t0 + lat - 1) @(negedge clk_1mhz);
    mole_pos = 4'd3;
    @(negedge clk_1mhz);
    chk("esc_wrong.miss_pulse", int'(miss_pulse), 1);
    chk_state("esc_wrong", 12, 8, 9, 0);
    @(negedge clk_1mhz);
    chk("esc_wrong.pulse_width", int'(miss_pulse), 0);
    btn = 8'h00;
    wait_ms(8);

    // Escape and hit on the new mole in the same cycle
    align_tick_phase();
    btn = 8'h01;
    t0 = cyc;
    while (cyc < t0 + lat - 1) @(negedge clk_1mhz);
    mole_pos = 4'd1;
    @(negedge clk_1mhz);
    chk("esc_hit.hit_pulse", int'(hit_pulse), 1);
    chk("esc_hit.miss_pulse", int'(miss_pulse), 1);
    chk_state("esc_hit", 13, 9, 10, 1);
    btn = 8'h00;
    wait_ms(8);

    // Asynchronous reset in the middle of a debounce
    btn = 8'h01;
    repeat (2 + 3 * CPM + 1) @(negedge clk_1mhz);
    #1 rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 0, 0, 0);
    chk("async_rst.hit_pulse", int'(hit_pulse), 0);
    chk("async_rst.miss_pulse", int'(miss_pulse), 0);
    repeat (2) @(negedge clk_1mhz);
    rst = 1'b0;
    t0 = cyc;
    wait_hit(t0, lat);
    chk_rng("post_rst_latency", lat, (DB - 1) * CPM, (DB + 1) * CPM + 3);
    chk_state("post_rst", 1, 1, 0, 1);
    btn = 8'h00;
    wait_ms(8);

    // Saturation of score and hit count, then hold while disabled
    @(negedge clk_1mhz);
    enable = 1'b0;
    mole_pos = 4'd0;
    wait_ms(1);
    enable = 1'b1;
    wait_ms(1);
    for (int k = 0; k < 332; k++)
      apply_vec(2'd3, (k % 2 == 1) ? 4'd2 : 4'd1, (k % 2 == 1) ? 8'h02 : 8'h01);
    chk_state("sat996", 996, 255, 0, 1);
    apply_vec(2'd2, 4'd1, 8'h01);
    chk_state("sat998", 998, 255, 0, 1);
    apply_vec(2'd3, 4'd2, 8'h02);
    chk_state("sat999", 999, 255, 0, 1);
    apply_vec(2'd3, 4'd1, 8'h01);
    chk_state("sat_hold", 999, 255, 0, 1);
    @(negedge clk_1mhz);
    enable = 1'b0;
    hp0 = hp_cnt;
    mp0 = mp_cnt;
    apply_vec(2'd3, 4'd2, 8'h02);
    apply_vec(2'd3, 4'd0, 8'h01);
    chk_state("disabled", 999, 255, 0, 0);
    chk("disabled.hit_pulses", hp_cnt, hp0);
    chk("disabled.miss_pulses", mp_cnt, mp0);
    @(negedge clk_1mhz);
    enable = 1'b1;
    repeat (2) @(negedge clk_1mhz);
    chk_state("new_game", 0, 0, 0, 0);

    // Miss counter saturation
    for (int k = 0; k < 258; k++) apply_vec(2'd1, 4'd0, 8'h10);
    chk_state("miss_sat", 0, 0, 255, 0);

    // Random press sequences against the model
    @(negedge clk_1mhz);
    enable = 1'b0;
    mole_pos = 4'd0;
    wait_ms(1);
    enable = 1'b1;
    wait_ms(1);
    m_pos = 0; m_hit = 0; m_score = 0; m_hits = 0; m_miss = 0;
    for (int k = 0; k < 40; k++) begin
      st = $urandom_range(0, 3);
      p  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
      r  = $urandom_range(0, 3);
      case (r)
        0:       m = 0;
        1:       m = is_valid(p) ? (1 << (p - 1)) : (1 << $urandom_range(0, 7));
        2:       m = 1 << $urandom_range(0, 7);
        default: m = $urandom_range(1, 255);
      endcase
      apply_vec(st[1:0], p[3:0], m[7:0]);
      model_event(st, p, m);
      chk_state($sformatf("rand%0d", k), m_score, m_hits, m_miss, m_hit);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
